microword_issue: RTL and testbench



---
 rtl/microaddr_types.sv | 18 +
 rtl/microword_types.sv | 22 ++
 rtl/microword_issue.sv | 96 +++++++++
 tb/tb_microword_issue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/microaddr_types.sv
// Shared sequencing types between the microcode issue stage and the micro-address counter.
package microaddr_types;

  localparam int UADDR_W = 10;

  typedef logic [UADDR_W-1:0] uaddr;

  // 3-bit encoding leaves room for counter-defined commands beyond the named ones.
  typedef enum logic [2:0] {
    NONE   = 3'd0,
    INC    = 3'd1,
    LOAD   = 3'd2,
    LOADNE = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } cmd;

endpackage

// File: rtl/microword_types.sv
// Microword layout as read from the microcode ROM.
package microword_types;

  localparam int CTRL_W_DEF = 16;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2
  } mem_op;

  typedef struct packed {
    microaddr_types::cmd   seq;
    microaddr_types::uaddr target;
    mem_op                 mem;
    logic                  flag_en;
    logic [CTRL_W_DEF-1:0] ctrl;
  } word;

  localparam int WORD_W = $bits(word);

endpackage

// File: rtl/microword_issue.sv
// Issues one microword per completing cycle: stretches memory ops until mem_ack, gates strobes,
// keeps the Z flag and vectors to a fault routine when memory fails to answer in time.
module microword_issue
  import microword_types::*;
#(
  parameter int          CTRL_W    = CTRL_W_DEF,
  parameter int          TIMEOUT   = 64,
  parameter int unsigned FAULT_VEC = 'h0F0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  word                   uword,
  input  logic                  alu_zero,
  input  logic                  mem_ack,
  output microaddr_types::cmd   cmd,
  output microaddr_types::uaddr load_addr,
  output logic                  zflag,
  output logic [CTRL_W-1:0]     ctrl,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  fault
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {
    S_EXEC = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             zflag_q, zflag_nxt;
  logic             fault_q, fault_nxt;
  logic             is_mem, complete, timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_EXEC;
      wait_cnt <= '0;
      zflag_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      zflag_q  <= zflag_nxt;
      fault_q  <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    zflag_nxt = zflag_q;
    fault_nxt = fault_q;
    cmd       = microaddr_types::NONE;
    load_addr = '0;
    ctrl      = '0;
    mem_req   = 1'b0;
    mem_write = 1'b0;

    is_mem   = (uword.mem != MEM_NONE);
    // A late ack on the last allowed cycle still counts as completion.
    complete = is_mem ? mem_ack : (state == S_EXEC);
    timeout  = (state == S_WAIT) && !complete && (wait_cnt == CNT_W'(TIMEOUT - 1));

    if (!reset) begin
      if (complete) begin
        cmd       = uword.seq;
        load_addr = uword.target;
        ctrl      = CTRL_W'(uword.ctrl);
        if (uword.flag_en) zflag_nxt = alu_zero;
        state_nxt = S_EXEC;
        cnt_nxt   = '0;
      end else if (timeout) begin
        cmd       = microaddr_types::LOAD;
        load_addr = microaddr_types::uaddr'(FAULT_VEC);
        fault_nxt = 1'b1;
        state_nxt = S_EXEC;
        cnt_nxt   = '0;
      end else if (state == S_EXEC) begin
        state_nxt = S_WAIT;
        cnt_nxt   = CNT_W'(1);
      end else begin
        cnt_nxt   = wait_cnt + CNT_W'(1);
      end

      mem_req   = (is_mem || state == S_WAIT) && !timeout;
      mem_write = mem_req && (uword.mem == MEM_WR);
    end
  end

  assign zflag = zflag_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_microword_issue.sv
// Scoreboarded random + directed bench for microword_issue with a short memory timeout.
module tb_microword_issue;
  import microword_types::*;

  localparam int          TO = 4;
  localparam int unsigned FV = 'h0F0;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  word                       uword = '0;
  logic                      alu_zero = 1'b0;
  logic                      mem_ack = 1'b0;
  microaddr_types::cmd       cmd;
  microaddr_types::uaddr     load_addr;
  logic                      zflag;
  logic [CTRL_W_DEF-1:0]     ctrl;
  logic                      mem_req, mem_write, fault;

  microword_issue #(.CTRL_W(CTRL_W_DEF), .TIMEOUT(TO), .FAULT_VEC(FV)) dut (
    .clk(clk), .reset(reset), .uword(uword), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .cmd(cmd), .load_addr(load_addr), .zflag(zflag), .ctrl(ctrl),
    .mem_req(mem_req), .mem_write(mem_write), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    microaddr_types::cmd   c;
    microaddr_types::uaddr a;
    logic [CTRL_W_DEF-1:0] s;
    logic                  req, wr, z, f;
    int                    id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mz = 1'b0;
  logic mf = 1'b0;
  int   instr_no = 0;

  task automatic push(input microaddr_types::cmd c, input microaddr_types::uaddr a,
                      input logic [CTRL_W_DEF-1:0] s, input logic req, input logic wr);
    exp_t e;
    e.c = c; e.a = a; e.s = s; e.req = req; e.wr = wr; e.z = mz; e.f = mf; e.id = instr_no;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({cmd, load_addr, ctrl, mem_req, mem_write, zflag, fault} !==
          {e.c, e.a, e.s, e.req, e.wr, e.z, e.f}) begin
        n_bad++;
        $display("FAIL cycle_out instr %0d: got cmd=%0d addr=%h ctrl=%h req=%b wr=%b z=%b f=%b, want cmd=%0d addr=%h ctrl=%h req=%b wr=%b z=%b f=%b",
                 e.id, cmd, load_addr, ctrl, mem_req, mem_write, zflag, fault,
                 e.c, e.a, e.s, e.req, e.wr, e.z, e.f);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word mk(input microaddr_types::cmd s, input microaddr_types::uaddr t,
                             input mem_op m, input logic fe, input logic [CTRL_W_DEF-1:0] c);
    word w;
    w.seq = s; w.target = t; w.mem = m; w.flag_en = fe; w.ctrl = c;
    return w;
  endfunction

  // Reset cycles: outputs idle, registered flags still show their pre-reset values.
  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      reset    = 1'b1;
      uword    = mk(microaddr_types::cmd'(3'($urandom)), microaddr_types::uaddr'($urandom),
                    mem_op'(2'($urandom_range(0, 2))), 1'($urandom), CTRL_W_DEF'($urandom));
      mem_ack  = 1'($urandom);
      alu_zero = 1'($urandom);
      push(microaddr_types::NONE, '0, '0, 1'b0, 1'b0);
      mz = 1'b0;
      mf = 1'b0;
    end
  endtask

  // One microinstruction: ack arrives on cycle k (0 = never); az: 0/1 fixed, 2 random;
  // maxc > 0 stops driving after that many cycles (instruction abandoned).
  task automatic do_instr(input word w, input int k, input int az, input int maxc);
    instr_no++;
    for (int i = 1; i <= TO; i++) begin
      if (maxc > 0 && i > maxc) return;
      tick();
      reset    = 1'b0;
      uword    = w;
      alu_zero = (az == 2) ? 1'($urandom) : (az != 0);
      mem_ack  = (w.mem == MEM_NONE) ? 1'($urandom) : (i == k);
      if (w.mem == MEM_NONE || i == k) begin
        push(w.seq, w.target, w.ctrl, w.mem != MEM_NONE, w.mem == MEM_WR);
        if (w.flag_en) mz = alu_zero;
        return;
      end else if (i == TO) begin
        push(microaddr_types::LOAD, microaddr_types::uaddr'(FV), '0, 1'b0, 1'b0);
        mf = 1'b1;
        return;
      end else begin
        push(microaddr_types::NONE, '0, '0, 1'b1, w.mem == MEM_WR);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got still running, want done");
    $fatal(1);
  end

  initial begin
    word w;
    int  k;
    reset_cycles(2);

    do_instr(mk(microaddr_types::INC, '0, MEM_NONE, 1'b0, 16'h00A5), 0, 2, 0);
    do_instr(mk(microaddr_types::LOAD, 10'h12, MEM_RD, 1'b0, 16'h5A5A), 4, 2, 0);
    do_instr(mk(microaddr_types::INC, 10'h3, MEM_WR, 1'b0, 16'h1111), 1, 2, 0);

    do_instr(mk(microaddr_types::INC, '0, MEM_NONE, 1'b1, 16'h0001), 0, 1, 0);
    do_instr(mk(microaddr_types::LOADNE, 10'h30, MEM_NONE, 1'b0, 16'h0002), 0, 2, 0);
    do_instr(mk(microaddr_types::INC, '0, MEM_NONE, 1'b1, 16'h0004), 0, 0, 0);
    do_instr(mk(microaddr_types::LOADNE, 10'h30, MEM_NONE, 1'b0, 16'h0008), 0, 2, 0);

    do_instr(mk(microaddr_types::LOAD, 10'h40, MEM_RD, 1'b1, 16'h0077), 0, 2, 0);
    do_instr(mk(microaddr_types::INC, '0, MEM_NONE, 1'b0, 16'h0010), 0, 2, 0);
    do_instr(mk(microaddr_types::INC, '0, MEM_WR, 1'b0, 16'h0020), 2, 2, 0);
    reset_cycles(1);
    do_instr(mk(microaddr_types::LOAD, 10'h40, MEM_RD, 1'b1, 16'h0077), TO, 1, 0);
    do_instr(mk(microaddr_types::INC, '0, MEM_NONE, 1'b0, 16'h0040), 0, 2, 0);

    do_instr(mk(microaddr_types::LOAD, 10'h55, MEM_RD, 1'b1, 16'h0080), 0, 1, 2);
    reset_cycles(1);
    do_instr(mk(microaddr_types::INC, '0, MEM_NONE, 1'b0, 16'h0100), 0, 2, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) reset_cycles($urandom_range(1, 2));
      w = mk(microaddr_types::cmd'(3'($urandom)), microaddr_types::uaddr'($urandom),
             mem_op'(2'($urandom_range(0, 2))), 1'($urandom), CTRL_W_DEF'($urandom));
      k = $urandom_range(0, TO + 1);
      do_instr(w, k, 2, 0);
    end

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
